// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel back end of the shift chain: samples one bit per clock,
// frames start/data(LSB first)/optional even parity/stop and reports the result.
module serial_frame_receiver #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy
);

  // state    | meaning
  // S_IDLE   | waiting for a start bit (sin=1)
  // S_DATA   | sampling data bit r_cnt into the holding register
  // S_PARITY | sampling the even-parity bit
  // S_STOP   | sampling the stop bit and reporting the frame
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_par_bit;
  logic [DATA_W-1:0] r_data_out;
  logic              r_valid;
  logic              r_par_err;
  logic              r_frame_err;

  logic w_last_bit;
  logic w_par_ok;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));
  assign w_par_ok   = !PARITY_EN || ((^r_hold) == r_par_bit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_par_bit   <= 1'b0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sin) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end
        end
        S_DATA: begin
          r_hold[r_cnt] <= sin;
          // hold the counter on the last bit so it never wraps inside a frame
          if (w_last_bit) begin
            r_state <= PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          r_par_bit <= sin;
          r_state   <= S_STOP;
        end
        S_STOP: begin
          // a 1 here is a framing error, never a new start bit
          r_state <= S_IDLE;
          if (sin) begin
            r_frame_err <= 1'b1;
          end else if (w_par_ok) begin
            r_data_out <= r_hold;
            r_valid    <= 1'b1;
          end else begin
            r_par_err <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = r_data_out;
  assign valid     = r_valid;
  assign par_err   = r_par_err;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: one instance with parity, one without.
module tb_serial_frame_receiver;

  typedef struct {
    int         kind;   // 0 valid, 1 par_err, 2 frame_err
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sin0, sin1;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int   n_cmp;
  int   n_bad;
  int   cyc;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut_par (
    .clk(clk), .rst(rst), .sin(sin0), .data_out(dout0), .valid(valid0),
    .par_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1'b0)) u_dut_nopar (
    .clk(clk), .rst(rst), .sin(sin1), .data_out(dout1), .valid(valid1),
    .par_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, got, want);
    end
  endtask

  task automatic mon(input int sel, input logic v, input logic p, input logic f,
                     input logic [7:0] d);
    exp_t e;
    int   kind;
    if ((int'(v) + int'(p) + int'(f)) > 1) begin
      check($sformatf("dut%0d pulses_onehot", sel), int'({v, p, f}), 0);
    end else if (v || p || f) begin
      kind = v ? 0 : (p ? 1 : 2);
      if ((sel == 0 && exp_q0.size() == 0) || (sel == 1 && exp_q1.size() == 0)) begin
        check($sformatf("dut%0d unexpected_pulse_kind", sel), kind, -1);
      end else begin
        e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("dut%0d pulse_kind", sel), kind, e.kind);
        check($sformatf("dut%0d data_out", sel), int'(d), int'(e.data));
        check($sformatf("dut%0d pulse_cycle", sel), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0, valid0, perr0, ferr0, dout0);
      mon(1, valid1, perr1, ferr1, dout1);
    end
  end

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  task automatic drive_bit(input int sel, input logic b, input logic exp_busy);
    @(negedge clk);
    check($sformatf("dut%0d busy", sel), int'(busy_of(sel)), int'(exp_busy));
    if (sel == 0) sin0 = b;
    else          sin1 = b;
  endtask

  task automatic idle(input int sel, input int n);
    for (int i = 0; i < n; i++) drive_bit(sel, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic stop, input int kind, input logic [7:0] exp_data);
    exp_t e;
    drive_bit(sel, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 1'b1);
    if (sel == 0) drive_bit(sel, pbit, 1'b1);
    drive_bit(sel, stop, 1'b1);
    e.kind = kind;
    e.data = exp_data;
    e.cyc  = cyc + 1;
    if (sel == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
  endtask

  task automatic partial_frame(input int sel, input logic [7:0] d, input int nbits);
    drive_bit(sel, 1'b1, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], 1'b1);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      sin0 = ~sin0;
      sin1 = ~sin1;
      @(negedge clk);
    end
    check("dut0 reset_outputs", int'({dout0, valid0, perr0, ferr0, busy0}), 0);
    check("dut1 reset_outputs", int'({dout1, valid1, perr1, ferr1, busy1}), 0);
    sin0 = 1'b0;
    sin1 = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    sin0  = 1'b0;
    sin1  = 1'b0;

    do_reset(2);

    // parity instance: good, parity error, frame error
    send_frame(0, 8'hA5, 1'b0, 1'b0, 0, 8'hA5);
    send_frame(0, 8'h01, 1'b0, 1'b0, 1, 8'hA5);
    send_frame(0, 8'h3C, 1'b0, 1'b1, 2, 8'hA5);
    idle(0, 2);
    // back-to-back, no idle gap
    send_frame(0, 8'h3C, 1'b0, 1'b0, 0, 8'h3C);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 0, 8'hFF);
    send_frame(0, 8'h07, 1'b1, 1'b0, 0, 8'h07);
    // bad parity and bad stop together reports only the framing error
    send_frame(0, 8'h01, 1'b0, 1'b1, 2, 8'h07);
    idle(0, 2);
    // abort mid-frame, then a full frame
    partial_frame(0, 8'hA5, 4);
    do_reset(2);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 0, 8'h5A);
    idle(0, 2);

    // no-parity instance
    send_frame(1, 8'hA5, 1'b0, 1'b0, 0, 8'hA5);
    partial_frame(1, 8'hA5, 4);
    do_reset(2);
    send_frame(1, 8'h5A, 1'b0, 1'b0, 0, 8'h5A);
    send_frame(1, 8'h81, 1'b0, 1'b1, 2, 8'h5A);
    idle(1, 1);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 0, 8'h3C);
    idle(1, 3);

    check("dut0 pending_expectations", exp_q0.size(), 0);
    check("dut1 pending_expectations", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Downstream consumer of the four-bit serial shifter's output bit stream. Samples one bit per clock, detects a start bit, and assembles a framed word (start, DATA_W data bits LSB-first, optional even parity, stop). Checks the frame and presents the word in parallel with a one-cycle valid pulse. Parity and framing errors are flagged. This is the serial-to-parallel back end of the shift chain.

## Interface
- DATA_W, 8, number of data bits per frame (≥2)
- PARITY_EN, 1, 1 = even parity bit present after data; 0 = no parity bit
- clk  input  1  rising-edge clock; one serial bit per cycle
- rst  input  1  asynchronous, active-low reset
- sin  input  1  serial bit stream (shifter output); idle level 0
- data_out  output  DATA_W  last correctly received word
- valid  output  1  one-cycle pulse: data_out just updated with a good word
- par_err  output  1  one-cycle pulse: parity mismatch on the frame just ended
- frame_err  output  1  one-cycle pulse: stop bit was 1
- busy  output  1  high while a frame is in progress (any state except IDLE)

## Operation
- Frame on sin: start bit = 1; then DATA_W data bits, LSB first; then parity bit if PARITY_EN; then stop bit = 0.
- Even parity: the data bits plus the parity bit contain an even number of ones.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: sin=1 → DATA with bit counter cleared; sin=0 → stay.
  - DATA: shift sin into the holding register at position cnt; cnt increments. After bit DATA_W-1, go to PARITY (PARITY_EN=1) or STOP.
  - PARITY: capture the parity bit → STOP.
  - STOP: always → IDLE.
    - sin=0 and parity OK (or PARITY_EN=0): data_out ← holding register, pulse valid.
    - sin=0 and parity bad: pulse par_err; data_out unchanged.
    - sin=1: pulse frame_err only (par_err not asserted, even if parity also bad); data_out unchanged. The 1 sampled in STOP is never reinterpreted as a start bit.
- Counter width: clog2(DATA_W). The counter never wraps inside a frame.
- busy is combinational from state (state ≠ IDLE).
- Reset (rst=0, any time including mid-frame):
  - state ← IDLE, counter and holding register ← 0
  - data_out ← 0, valid/par_err/frame_err ← 0, busy ← 0
  - any partial frame is discarded

## Timing
- All sampling on the rising clk edge. valid, par_err and frame_err are registered.
- Edge E0 samples the start bit. Edges E1..E_DATA_W sample the data bits. Edge E_DATA_W+1 samples parity (if enabled). The next edge samples stop.
- Frame length: DATA_W+3 cycles with parity, DATA_W+2 without.
- Latency: valid/par_err/frame_err go high immediately after the stop-sampling edge, for exactly one cycle. data_out changes on that same edge.
- Back-to-back frames are supported. A start bit may be sampled on the edge directly after the stop edge, giving zero idle cycles. The pulse from frame N coincides with the start-bit cycle of frame N+1.
- At most one of valid/par_err/frame_err is high in any cycle.
- Reset release: the first edge with rst=1 acts as an IDLE sample.

## Test plan
- Reset: hold rst=0 for 2 cycles with sin toggling → data_out=0x00, valid=par_err=frame_err=busy=0.
- Good frame, DATA_W=8, PARITY_EN=1: sin = 1, 1,0,1,0,0,1,0,1, 0, 0 (0xA5, parity 0, stop 0) → after the 11th edge, valid=1 for one cycle and data_out=0xA5; busy high for edges 1–10.
- Parity error: 0x01 sent with parity bit 0 → par_err=1 for one cycle, valid=0, data_out stays 0xA5.
- Frame error: 0x3C with parity 0 and stop bit 1 → frame_err=1, par_err=0, valid=0. The next cycle is IDLE; the stop 1 is not taken as a start bit.
- Back-to-back: 0x3C frame then immediately 0xFF frame (parity 0 each), no idle gap → two valid pulses 11 cycles apart, data_out=0x3C then 0xFF.
- Reset mid-frame: assert rst=0 after the 4th data bit of 0xA5, release, then send a full 0x5A frame → no pulse for the aborted frame; valid with data_out=0x5A at the end of the second frame. Repeat with PARITY_EN=0 (10-cycle frame) → valid on the 10th edge.
